// File: rtl/minterm_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : minterm_sweep_checker
// Purpose  : Sequential equivalence checker for two N-input combinational
//            functions. Sweeps x through every minterm 0 .. 2^N-1, waits
//            SETTLE cycles per minterm, samples f1/f2, and accumulates the
//            mismatch count, the lowest failing minterm and the on-set size
//            of f1.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N               number of function inputs (1..8)
//   SETTLE          cycles from driving x to sampling f1/f2 (1..15)
// Ports
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   start_i         sweep request, honoured only while idle
//   mode_i          latched with start: 0 = f1 == f2, 1 = f1 == ~f2
//   f1_i, f2_i      outputs of the two functions under test (driven from x_o)
//   x_o             current minterm; x_o[N-1] is x1 (MSB)
//   busy_o          high while a sweep runs
//   done_o          one-cycle pulse when the results become final
//   equal_o         1 when the last sweep found no failing minterm
//   mismatch_cnt_o  number of failing minterms
//   first_bad_o     lowest failing minterm (0 when none failed)
//   ones_cnt_o      number of minterms where f1 = 1
// ============================================================================
module minterm_sweep_checker #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic         f1_i,
  input  logic         f2_i,
  output logic [N-1:0] x_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         equal_o,
  output logic [N:0]   mismatch_cnt_o,
  output logic [N-1:0] first_bad_o,
  output logic [N:0]   ones_cnt_o
);

  // The settle counter only ever holds 1..SETTLE, and SETTLE <= 15.
  localparam int            C_CW       = 4;
  localparam logic [C_CW-1:0] C_SETTLE = C_CW'(SETTLE);
  localparam logic [C_CW-1:0] C_CNT_ONE = C_CW'(1);
  localparam logic [N-1:0]  C_X_LAST   = '1;
  localparam logic [N-1:0]  C_X_ONE    = N'(1);
  // Result counters are one bit wider than x so 2^N fits without overflow.
  localparam logic [N:0]    C_RES_ONE  = (N+1)'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q,    state_d;
  logic [N-1:0]      x_q,        x_d;
  logic              done_q,     done_d;
  logic              equal_q,    equal_d;
  logic [N:0]        mis_q,      mis_d;
  logic [N-1:0]      first_q,    first_d;
  logic [N:0]        ones_q,     ones_d;
  logic [C_CW-1:0]   cnt_q,      cnt_d;
  logic              mode_q,     mode_d;

  logic              fail_w;
  logic              sample_w;

  // In complement mode the two functions must disagree everywhere, so a
  // minterm fails exactly when they agree.
  assign fail_w   = mode_q ? (f1_i == f2_i) : (f1_i != f2_i);
  assign sample_w = (cnt_q == C_SETTLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      mis_q   <= '0;
      first_q <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      mis_q   <= mis_d;
      first_q <= first_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    done_d  = 1'b0;
    equal_d = equal_q;
    mis_d   = mis_q;
    first_d = first_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          x_d     = '0;
          mode_d  = mode_i;
          mis_d   = '0;
          ones_d  = '0;
          first_d = '0;
          equal_d = 1'b0;
          cnt_d   = C_CNT_ONE;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + C_CNT_ONE;
        if (sample_w) begin
          // Minterms are visited in ascending order, so the first failure
          // seen is the lowest failing index.
          if (fail_w && (mis_q == '0)) begin
            first_d = x_q;
          end
          if (fail_w) begin
            mis_d = mis_q + C_RES_ONE;
          end
          if (f1_i) begin
            ones_d = ones_q + C_RES_ONE;
          end

          if (x_q == C_X_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            x_d     = '0;
            cnt_d   = '0;
            // Uses the updated count so the final sample is included.
            equal_d = (mis_d == '0);
          end else begin
            x_d   = x_q + C_X_ONE;
            cnt_d = C_CNT_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign x_o            = x_q;
  assign busy_o         = (state_q == S_RUN);
  assign done_o         = done_q;
  assign equal_o        = equal_q;
  assign mismatch_cnt_o = mis_q;
  assign first_bad_o    = first_q;
  assign ones_cnt_o     = ones_q;

endmodule
`default_nettype wire

// File: tb/tb_minterm_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_minterm_sweep_checker
// Purpose  : Self-checking bench for minterm_sweep_checker. Four instances
//            cover the configurations (N,SETTLE) = (3,1), (4,3), (3,2), (2,1).
//            Functions f1/f2 are truth tables held in the bench; expected
//            results come from a direct enumeration of those tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minterm_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_all, rst_one, start_drv, mode_drv;
  int          sel;
  logic [15:0] tt1, tt2;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- instance A : N=3 SETTLE=1 ----------------
  logic       rst_a, start_a, f1_a, f2_a, busy_a, done_a, eq_a;
  logic [2:0] x_a, first_a;
  logic [3:0] mis_a, ones_a;
  assign rst_a   = rst_all | (rst_one & (sel == 0));
  assign start_a = start_drv & (sel == 0);
  assign f1_a    = tt1[x_a];
  assign f2_a    = tt2[x_a];
  minterm_sweep_checker #(.N(3), .SETTLE(1)) u_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .mode_i(mode_drv),
    .f1_i(f1_a), .f2_i(f2_a), .x_o(x_a), .busy_o(busy_a), .done_o(done_a),
    .equal_o(eq_a), .mismatch_cnt_o(mis_a), .first_bad_o(first_a),
    .ones_cnt_o(ones_a));

  // ---------------- instance B : N=4 SETTLE=3 ----------------
  logic       rst_b, start_b, f1_b, f2_b, busy_b, done_b, eq_b;
  logic [3:0] x_b, first_b;
  logic [4:0] mis_b, ones_b;
  assign rst_b   = rst_all | (rst_one & (sel == 1));
  assign start_b = start_drv & (sel == 1);
  assign f1_b    = tt1[x_b];
  assign f2_b    = tt2[x_b];
  minterm_sweep_checker #(.N(4), .SETTLE(3)) u_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .mode_i(mode_drv),
    .f1_i(f1_b), .f2_i(f2_b), .x_o(x_b), .busy_o(busy_b), .done_o(done_b),
    .equal_o(eq_b), .mismatch_cnt_o(mis_b), .first_bad_o(first_b),
    .ones_cnt_o(ones_b));

  // ---------------- instance C : N=3 SETTLE=2 ----------------
  logic       rst_c, start_c, f1_c, f2_c, busy_c, done_c, eq_c;
  logic [2:0] x_c, first_c;
  logic [3:0] mis_c, ones_c;
  assign rst_c   = rst_all | (rst_one & (sel == 2));
  assign start_c = start_drv & (sel == 2);
  assign f1_c    = tt1[x_c];
  assign f2_c    = tt2[x_c];
  minterm_sweep_checker #(.N(3), .SETTLE(2)) u_c (
    .clk_i(clk), .rst_i(rst_c), .start_i(start_c), .mode_i(mode_drv),
    .f1_i(f1_c), .f2_i(f2_c), .x_o(x_c), .busy_o(busy_c), .done_o(done_c),
    .equal_o(eq_c), .mismatch_cnt_o(mis_c), .first_bad_o(first_c),
    .ones_cnt_o(ones_c));

  // ---------------- instance D : N=2 SETTLE=1 ----------------
  logic       rst_d, start_d, f1_d, f2_d, busy_d, done_d, eq_d;
  logic [1:0] x_d, first_d;
  logic [2:0] mis_d, ones_d;
  assign rst_d   = rst_all | (rst_one & (sel == 3));
  assign start_d = start_drv & (sel == 3);
  assign f1_d    = tt1[x_d];
  assign f2_d    = tt2[x_d];
  minterm_sweep_checker #(.N(2), .SETTLE(1)) u_d (
    .clk_i(clk), .rst_i(rst_d), .start_i(start_d), .mode_i(mode_drv),
    .f1_i(f1_d), .f2_i(f2_d), .x_o(x_d), .busy_o(busy_d), .done_o(done_d),
    .equal_o(eq_d), .mismatch_cnt_o(mis_d), .first_bad_o(first_d),
    .ones_cnt_o(ones_d));

  // Outputs of the selected instance, zero-extended to a common width.
  logic [31:0] o_x, o_busy, o_done, o_eq, o_mis, o_first, o_ones;
  always_comb begin
    o_x = '0; o_busy = '0; o_done = '0; o_eq = '0;
    o_mis = '0; o_first = '0; o_ones = '0;
    case (sel)
      0: begin o_x = 32'(x_a); o_busy = 32'(busy_a); o_done = 32'(done_a); o_eq = 32'(eq_a);
               o_mis = 32'(mis_a); o_first = 32'(first_a); o_ones = 32'(ones_a); end
      1: begin o_x = 32'(x_b); o_busy = 32'(busy_b); o_done = 32'(done_b); o_eq = 32'(eq_b);
               o_mis = 32'(mis_b); o_first = 32'(first_b); o_ones = 32'(ones_b); end
      2: begin o_x = 32'(x_c); o_busy = 32'(busy_c); o_done = 32'(done_c); o_eq = 32'(eq_c);
               o_mis = 32'(mis_c); o_first = 32'(first_c); o_ones = 32'(ones_c); end
      default: begin o_x = 32'(x_d); o_busy = 32'(busy_d); o_done = 32'(done_d); o_eq = 32'(eq_d);
               o_mis = 32'(mis_d); o_first = 32'(first_d); o_ones = 32'(ones_d); end
    endcase
  end

  function automatic int cfg_n(input int s);
    case (s)
      0: return 3;
      1: return 4;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int cfg_s(input int s);
    case (s)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  // Reference: enumerate every minterm of the truth tables directly.
  task automatic model(input int n, input logic [15:0] a, input logic [15:0] b,
                       input logic m, output int eq, output int cnt,
                       output int first, output int ones);
    cnt = 0; first = 0; ones = 0;
    for (int k = 0; k < (1 << n); k++) begin
      logic fa, fb, fl;
      fa = a[k];
      fb = b[k];
      fl = m ? (fa == fb) : (fa != fb);
      if (fl && cnt == 0) first = k;
      if (fl) cnt++;
      if (fa) ones++;
    end
    eq = (cnt == 0) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, "x", o_x, 0);        chk(tag, "busy", o_busy, 0);
    chk(tag, "done", o_done, 0);  chk(tag, "equal", o_eq, 0);
    chk(tag, "mis", o_mis, 0);    chk(tag, "first", o_first, 0);
    chk(tag, "ones", o_ones, 0);
  endtask

  // Edge 0: start accepted, results cleared, x = 0.
  task automatic launch(input string tag, input logic m0);
    mode_drv  = m0;
    start_drv = 1'b1;
    step();
    chk(tag, "e0.busy", o_busy, 1);  chk(tag, "e0.x", o_x, 0);
    chk(tag, "e0.done", o_done, 0);  chk(tag, "e0.mis", o_mis, 0);
    chk(tag, "e0.ones", o_ones, 0);  chk(tag, "e0.first", o_first, 0);
    chk(tag, "e0.equal", o_eq, 0);
  endtask

  // Edges 1 .. 2^N*SETTLE of a sweep launched with mode m0. Bits of pulse
  // mark edges before which start is raised with the opposite mode.
  task automatic body(input string tag, input logic m0, input logic [31:0] pulse,
                      input logic hold);
    int n, s, total, eq, cnt, first, ones;
    n = cfg_n(sel);
    s = cfg_s(sel);
    total = (1 << n) * s;
    model(n, tt1, tt2, m0, eq, cnt, first, ones);
    for (int e = 1; e <= total; e++) begin
      if (e < 32 && ((pulse >> e) & 32'd1) != 0) begin
        start_drv = 1'b1;
        mode_drv  = ~m0;
      end else begin
        start_drv = hold;
        mode_drv  = m0;
      end
      step();
      if (e < total) begin
        chk(tag, "run.x", o_x, e / s);
        chk(tag, "run.busy", o_busy, 1);
        chk(tag, "run.done", o_done, 0);
      end
    end
    chk(tag, "end.done", o_done, 1);  chk(tag, "end.busy", o_busy, 0);
    chk(tag, "end.x", o_x, 0);        chk(tag, "equal", o_eq, eq);
    chk(tag, "mis", o_mis, cnt);      chk(tag, "first", o_first, first);
    chk(tag, "ones", o_ones, ones);
    if (!hold) begin
      start_drv = 1'b0;
      step();
      chk(tag, "post.done", o_done, 0); chk(tag, "post.busy", o_busy, 0);
      chk(tag, "hold.equal", o_eq, eq); chk(tag, "hold.mis", o_mis, cnt);
      chk(tag, "hold.first", o_first, first);
      chk(tag, "hold.ones", o_ones, ones);
    end
  endtask

  initial begin
    rst_all = 1'b1; rst_one = 1'b0; start_drv = 1'b0; mode_drv = 1'b0;
    sel = 0; tt1 = '0; tt2 = '0;
    repeat (3) step();
    rst_all = 1'b0;
    step();

    // Reset state of every instance.
    for (int i = 0; i < 4; i++) begin
      sel = i;
      #1;
      chk_all_zero("reset");
    end

    // XOR3 against itself.
    sel = 0; tt1 = 16'h0096; tt2 = 16'h0096;
    launch("xor3", 1'b0);
    body("xor3", 1'b0, 32'd0, 1'b0);

    // Two mismatches at minterms 0 and 2.
    tt1 = 16'h007E; tt2 = 16'h007B;
    launch("diff3", 1'b0);
    body("diff3", 1'b0, 32'd0, 1'b0);

    // N=4, SETTLE=3: f1 = (x1==x3)|(x2==x4), f2 = m(3,6,9,12).
    sel = 1; tt1 = '0; tt2 = 16'h1248;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] kv;
      kv = 4'(k);
      tt1[k] = (kv[3] == kv[1]) | (kv[2] == kv[0]);
    end
    launch("cmpl4", 1'b1);
    body("cmpl4", 1'b1, 32'd0, 1'b0);
    launch("cmpl4m0", 1'b0);
    body("cmpl4m0", 1'b0, 32'd0, 1'b0);

    // Mid-sweep reset on N=3 SETTLE=2, after a sweep left non-zero results.
    sel = 2; tt1 = 16'h007E; tt2 = 16'h007B;
    launch("rstpre", 1'b0);
    body("rstpre", 1'b0, 32'd0, 1'b0);
    launch("rstmid", 1'b0);
    start_drv = 1'b0;
    repeat (4) step();
    rst_one = 1'b1;
    step();
    rst_one = 1'b0;
    chk_all_zero("rstmid");
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rstmid", "nodone", o_done, 0);
    end
    launch("rstnew", 1'b0);
    body("rstnew", 1'b0, 32'd0, 1'b0);

    // start pulses at edges 3 and 7 with the other mode are ignored.
    sel = 0; tt1 = 16'h007E; tt2 = 16'h007B;
    launch("ignore", 1'b0);
    body("ignore", 1'b0, 32'h0000_0088, 1'b0);

    // start held high: done on edges 4 and 9, results cleared at edge 5.
    sel = 3; tt1 = 16'h0006; tt2 = 16'h0003;
    launch("b2b1", 1'b0);
    body("b2b1", 1'b0, 32'd0, 1'b1);
    launch("b2b2", 1'b0);
    body("b2b2", 1'b0, 32'd0, 1'b1);
    start_drv = 1'b0;
    step();
    chk("b2b", "post.done", o_done, 0);
    chk("b2b", "post.busy", o_busy, 0);

    // Randomized sweeps on all configurations.
    for (int i = 0; i < 12; i++) begin
      logic m;
      sel = int'($urandom_range(0, 3));
      m   = 1'($urandom_range(0, 1));
      tt1 = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       tt2 = m ? ~tt1 : tt1;
        1:       tt2 = (m ? ~tt1 : tt1) ^ (16'h1 << $urandom_range(0, 15));
        default: tt2 = 16'($urandom);
      endcase
      launch("rand", m);
      body("rand", m, 32'd0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/minterm_sweep_checker.md
# minterm_sweep_checker

Sequential, parametrised equivalence checker for N-input combinational functions. It sweeps the input vector through all 2^N minterms, drives it to two external function blocks (f1, f2), samples both outputs after a programmable settle time, and reports equality, mismatch count, first failing minterm and on-set size. It sits in the exercise test harness as the hardware counterpart of "prove f1 = f2 by functional simulation" for gate-level and continuous-assignment function modules.

## Interface
- N, default 3: number of function inputs; legal range 1..8.
- SETTLE, default 1: cycles between driving x and sampling f1/f2; legal range 1..15.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; takes effect on the rising edge of Clock.
- start  in  1  request a sweep; honoured only in IDLE.
- mode  in  1  sampled with start; 0: check f1 == f2; 1: check f1 == ~f2 (complement check).
- f1  in  1  output of function under test 1, driven from x.
- f2  in  1  output of function under test 2, driven from x.
- x  out  N  current minterm index; x[N-1] is x1 (MSB), x[0] is xN.
- busy  out  1  high while the sweep runs.
- done  out  1  one-cycle pulse when results are final.
- equal  out  1  1 when no mismatch was found in the last sweep.
- mismatch_cnt  out  N+1  number of failing minterms.
- first_bad  out  N  lowest failing minterm index; 0 when mismatch_cnt = 0.
- ones_cnt  out  N+1  number of minterms with f1 = 1 (on-set size of f1).

## Operation
- States: IDLE, RUN.
- Reset values: state IDLE, x 0, busy 0, done 0, equal 0, mismatch_cnt 0, first_bad 0, ones_cnt 0, settle counter 0, latched mode 0.
- IDLE + start=1: go to RUN; x <= 0; busy <= 1; mode latched; mismatch_cnt, ones_cnt, first_bad cleared; equal <= 0; settle counter <= 1.
- IDLE + start=0: outputs hold; x held at 0.
- RUN: settle counter increments each cycle. When counter = SETTLE, sample f1/f2 on that edge:
  - fail = (f1 != f2) when mode=0; fail = (f1 == f2) when mode=1.
  - fail and mismatch_cnt = 0: first_bad <= x.
  - fail: mismatch_cnt += 1. f1=1: ones_cnt += 1.
  - x < 2^N-1: x <= x+1; settle counter <= 1.
  - x = 2^N-1 (last minterm): state <= IDLE; busy <= 0; done <= 1; x <= 0; equal <= (final mismatch_cnt = 0), including the current sample.
- done is high for exactly one cycle. equal, mismatch_cnt, first_bad and ones_cnt hold until the next accepted start.
- start while busy: ignored, with no effect on the sweep or the latched mode.
- start in the done cycle: accepted, because the state is already IDLE.
- Counter widths: N+1 bits hold 2^N without overflow; x wraps 2^N-1 -> 0 only at sweep end.
- Reset mid-sweep: abort immediately; all outputs return to reset values; no done pulse.
- f1/f2 are treated as synchronous inputs: external logic is combinational from x and sampled only on settle edges.

## Timing
- The edge that samples start = edge 0; x = 0 is valid after edge 0.
- Minterm k is sampled at edge (k+1)·SETTLE, and x = k+1 is valid after that edge.
- The last sample, done and busy falling all occur on edge 2^N·SETTLE; busy is high for 2^N·SETTLE cycles.
- Back-to-back sweeps: when start is held high, the next sweep begins on the edge after the done cycle.

## Test plan
- N=3, SETTLE=1, mode=0, f1 = f2 = Σm(1,2,4,7) (XOR3), start pulse -> done on edge 8; equal=1; mismatch_cnt=0; first_bad=0; ones_cnt=4; busy high for 8 cycles.
- N=3, mode=0, f1 = Σm(1,2,3,4,5,6), f2 = Σm(0,1,3,4,5,6) -> equal=0; mismatch_cnt=2; first_bad=0; ones_cnt=6.
- N=4, SETTLE=3, mode=1, f1 = (x1&x3)|(~x1&~x3)|(x2&x4)|(~x2&~x4), f2 = Σm(3,6,9,12) -> done on edge 48; equal=1; mismatch_cnt=0; ones_cnt=12. The same stimulus with mode=0 -> mismatch_cnt=16, first_bad=0.
- Reset asserted at edge 5 of an N=3, SETTLE=2 sweep -> x=0, busy=0, all results 0, no done. A fresh start afterwards completes normally at edge 16.
- start pulsed at edges 3 and 7 during a sweep, with mode toggled -> ignored; done on the original edge 8; the result reflects the mode latched at edge 0.
- start held high continuously, N=2, SETTLE=1 -> done pulses on edges 4 and 9; the results are cleared at edge 5 and rebuilt.
